// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // One buffered fetch: the address it came from plus the instruction word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] word;
  } fetch_entry_t;

  // Instructions are word aligned; redirect targets drop their low two bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO with flush.
// Latency: a pushed entry is visible on dout the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap for free.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // Storage write; suppressed under reset or flush so nothing half-lands.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: sequential PC generation into a small buffer toward decode.
// Latency: one cycle from ROM address to inst/inst_pc when the buffer is empty.
// Backpressure: inst_ready low fills the buffer, then HOLD freezes HADDR until a pop.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  output logic [XLEN-1:0] HADDR,
  output logic            HWRITE,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_t  state;
  logic [XLEN-1:0] fetch_pc;
  logic          pop;
  logic          fetch;
  logic          buf_full;
  logic          buf_empty;
  logic [CW-1:0] buf_count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          unused_hrdata_hi;

  // Upper half of the ROM beat carries no instruction bits.
  assign unused_hrdata_hi = ^HRDATA[XLEN-1:ILEN];

  assign HADDR  = fetch_pc;
  assign HWRITE = 1'b0;
  assign HWDATA = '0;

  assign inst_valid = !buf_empty;
  assign inst       = head_entry.word;
  assign inst_pc    = head_entry.pc;

  assign pop = inst_valid && inst_ready;

  // HOLD is only ever entered full, so the full/pop test covers both live states.
  assign fetch = (state != BOOT) && !redirect_valid && (!buf_full || pop);

  assign push_entry.pc   = fetch_pc;
  assign push_entry.word = HRDATA[ILEN-1:0];

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_buf (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // Fetch FSM and PC: redirect beats everything except reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      state    <= RUN;
      fetch_pc <= align_pc(redirect_pc);
    end else begin
      if (fetch) fetch_pc <= fetch_pc + XLEN'(4);
      case (state)
        BOOT: state <= RUN;
        RUN:  if (buf_count == FULL_CNT && !pop) state <= HOLD;
        HOLD: if (pop) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: queue-based reference model plus directed scenarios.
// Latency: n/a.
// Backpressure: exercised through inst_ready patterns.
module tb_ifetch;

  localparam int DEPTH = 2;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        HCLK;
  logic        HRESETn;
  logic [63:0] HADDR;
  logic        HWRITE;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  int total = 0;
  int bad   = 0;

  ifetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .HADDR          (HADDR),
    .HWRITE         (HWRITE),
    .HWDATA         (HWDATA),
    .HRDATA         (HRDATA),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Instruction ROM: a few real words at the bottom, an address-derived pattern elsewhere.
  function automatic logic [31:0] rom(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h00400093;
      64'd4:   return 32'h00300113;
      64'd8:   return 32'h002081b3;
      64'd12:  return 32'h00118193;
      default: return a[31:0] ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign HRDATA = {32'hBAD0_BAD0, rom(HADDR)};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {pc, word} and the next address to fetch.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  bit          m_boot = 1'b1;
  bit          live   = 1'b0;
  bit          m_pop;
  bit          m_fetch;
  int          accepted = 0;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      q.delete();
      m_pc   = RST_PC;
      m_boot = 1'b1;
      live   = 1'b1;
    end else if (live) begin
      m_pop = (q.size() != 0) && inst_ready;
      if (m_pop) accepted++;
      if (redirect_valid) begin
        q.delete();
        m_pc   = {redirect_pc[63:2], 2'b00};
        m_boot = 1'b0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else begin
        m_fetch = (q.size() < DEPTH) || m_pop;
        if (m_pop) void'(q.pop_front());
        if (m_fetch) begin
          q.push_back({m_pc, rom(m_pc)});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  end

  // Every cycle after the first reset edge the DUT must match the model.
  always @(negedge HCLK) begin
    if (live) begin
      chk("haddr", HADDR, m_pc);
      chk("inst_valid", {63'd0, inst_valid}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("inst", {32'd0, inst}, {32'd0, q[0].w});
        chk("inst_pc", inst_pc, q[0].pc);
      end
      chk("hwrite", {63'd0, HWRITE}, 64'd0);
      chk("hwdata", HWDATA, 64'd0);
    end
  end

  // Apply inputs for the coming edge; outputs seen afterwards reflect the previous edge.
  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [63:0] rp);
    @(negedge HCLK);
    #1;
    HRESETn        = r;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  initial begin
    HRESETn = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset and in-order streaming
    repeat (3) drive(0, 1, 0, 64'h0);
    chk("rst_valid",  {63'd0, inst_valid}, 64'd0);
    chk("rst_haddr",  HADDR, 64'h0);
    chk("rst_hwrite", {63'd0, HWRITE}, 64'd0);
    chk("rst_hwdata", HWDATA, 64'd0);
    drive(1, 1, 0, 64'h0);
    chk("boot_valid", {63'd0, inst_valid}, 64'd0);
    drive(1, 1, 0, 64'h0);
    chk("run0_valid", {63'd0, inst_valid}, 64'd0);
    chk("run0_haddr", HADDR, 64'h0);
    drive(1, 1, 0, 64'h0);
    chk("s1_v0",  {63'd0, inst_valid}, 64'd1);
    chk("s1_i0",  {32'd0, inst}, 64'h00400093);
    chk("s1_p0",  inst_pc, 64'h0);
    drive(1, 1, 0, 64'h0);
    chk("s1_i1",  {32'd0, inst}, 64'h00300113);
    chk("s1_p1",  inst_pc, 64'h4);
    drive(1, 1, 0, 64'h0);
    chk("s1_i2",  {32'd0, inst}, 64'h002081b3);
    chk("s1_p2",  inst_pc, 64'h8);
    drive(1, 1, 0, 64'h0);
    chk("s1_i3",  {32'd0, inst}, 64'h00118193);
    chk("s1_p3",  inst_pc, 64'hC);
    repeat (3) drive(1, 1, 0, 64'h0);

    // Backpressure from boot: buffer fills to DEPTH, HADDR parks at 8
    repeat (2) drive(0, 0, 0, 64'h0);
    drive(1, 0, 0, 64'h0);
    repeat (5) drive(1, 0, 0, 64'h0);
    chk("hold_haddr", HADDR, 64'h8);
    chk("hold_head",  inst_pc, 64'h0);
    drive(1, 1, 0, 64'h0);
    chk("hold_haddr2", HADDR, 64'h8);
    drive(1, 1, 0, 64'h0);
    chk("rel_p4",    inst_pc, 64'h4);
    chk("rel_haddr", HADDR, 64'hC);
    drive(1, 1, 0, 64'h0);
    chk("rel_p8",    inst_pc, 64'h8);

    // Redirect with a full buffer
    repeat (3) drive(1, 0, 0, 64'h0);
    chk("pre_rd_valid", {63'd0, inst_valid}, 64'd1);
    drive(1, 0, 1, 64'h40);
    drive(1, 0, 0, 64'h0);
    chk("rd_valid", {63'd0, inst_valid}, 64'd0);
    chk("rd_haddr", HADDR, 64'h40);
    drive(1, 0, 0, 64'h0);
    chk("rd_p40",  inst_pc, 64'h40);
    chk("rd_i40",  {32'd0, inst}, 64'h5A5A0F4F);

    // Misaligned redirect with a simultaneous pop
    drive(1, 1, 1, 64'h43);
    drive(1, 1, 0, 64'h0);
    chk("rd43_valid", {63'd0, inst_valid}, 64'd0);
    chk("rd43_haddr", HADDR, 64'h40);
    drive(1, 1, 0, 64'h0);
    chk("rd43_p", inst_pc, 64'h40);

    // PC wraps past the top of the address space
    drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1, 1, 0, 64'h0);
    chk("wrap_haddr0", HADDR, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1, 1, 0, 64'h0);
    chk("wrap_haddr1", HADDR, 64'h0);
    chk("wrap_p",      inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_i",      {32'd0, inst}, 64'hA5A5F0F3);
    drive(1, 1, 0, 64'h0);
    chk("wrap_p0",     inst_pc, 64'h0);
    drive(1, 1, 0, 64'h0);

    // Reset mid-stream, then a redirect issued during BOOT
    drive(0, 1, 0, 64'h0);
    drive(1, 1, 1, 64'h80);
    chk("midrst_valid", {63'd0, inst_valid}, 64'd0);
    chk("midrst_haddr", HADDR, RST_PC);
    drive(1, 1, 0, 64'h0);
    chk("bootrd_haddr", HADDR, 64'h80);
    chk("bootrd_valid", {63'd0, inst_valid}, 64'd0);
    drive(1, 1, 0, 64'h0);
    chk("bootrd_p", inst_pc, 64'h80);

    // Mixed traffic checked by the model
    for (int i = 0; i < 40; i++) begin
      if (i == 17)      drive(1, 1'b0, 1, 64'h1000 + 64'(i));
      else if (i == 30) drive(1, 1'b1, 1, 64'h200);
      else              drive(1, (i % 3) != 0, 0, 64'h0);
    end
    repeat (4) drive(1, 1, 0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
